// File: rtl/seg_pkg.sv
// seg_pkg: shared BCD digit type, digit count and load clamp helper
package seg_pkg;
  typedef logic [3:0] bcd_t;
  localparam int NUM_DIGITS = 8;
  localparam bcd_t BCD_MAX = 4'd9;
  function automatic bcd_t bcd_clamp(bcd_t v);
    return v > BCD_MAX ? BCD_MAX : v;
  endfunction
endpackage

// File: rtl/bcd_digit_cell.sv
// bcd_digit_cell: combinational single-digit BCD increment/decrement with carry/borrow
module bcd_digit_cell
  import seg_pkg::*;
(
  input  bcd_t d_in,
  input  logic up,
  input  logic cin,
  output bcd_t d_out,
  output logic cout
);
  assign cout = cin & (up ? d_in == BCD_MAX : d_in == 4'd0);
  assign d_out = !cin ? d_in : cout ? (up ? 4'd0 : BCD_MAX) : (up ? d_in + 4'd1 : d_in - 4'd1);
endmodule

// File: rtl/bcd_counter8.sv
// bcd_counter8: eight-digit BCD up/down counter with prescaler, clamped load and wrap pulse
module bcd_counter8
  import seg_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int TICK_HZ = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [NUM_DIGITS*4-1:0] load_val,
  output logic [NUM_DIGITS*4-1:0] digits,
  output logic                    tick,
  output logic                    wrap
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW = $clog2(DIV);
  logic [PW-1:0] pcnt;
  logic [NUM_DIGITS:0] c;
  logic [NUM_DIGITS*4-1:0] nxt, ld;
  assign tick = pcnt == PW'(DIV - 1);
  assign c[0] = tick & en;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit_cell u_cell (
      .d_in (digits[4*i+:4]),
      .up   (up),
      .cin  (c[i]),
      .d_out(nxt[4*i+:4]),
      .cout (c[i+1])
    );
    assign ld[4*i+:4] = bcd_clamp(load_val[4*i+:4]);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt <= '0;
      digits <= '0;
      wrap <= 1'b0;
    end else begin
      pcnt <= tick ? '0 : pcnt + PW'(1);
      digits <= load ? ld : nxt;
      wrap <= !load & c[NUM_DIGITS];
    end
  end
endmodule

// File: tb/tb_bcd_counter8.sv
// tb_bcd_counter8: directed checks of prescaler timing, carry/borrow, wrap, load clamp and reset
module tb_bcd_counter8;
  localparam int DIV = 10;
  logic clk = 1'b0;
  logic rst_n, en, up, load;
  logic [31:0] load_val, digits;
  logic tick, wrap;
  int n_cmp = 0;
  int n_err = 0;
  bcd_counter8 #(.CLK_HZ(10), .TICK_HZ(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_val(load_val), .digits(digits), .tick(tick), .wrap(wrap)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_tick();
    for (int k = 0; k < 2 * DIV && !tick; k++) step();
    check("tick_wait", {31'd0, tick}, 32'd1);
  endtask
  task automatic do_load(input logic [31:0] v);
    load_val = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask
  initial begin
    logic [31:0] held;
    logic saw_tick;
    rst_n = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; load_val = '0;
    #1;
    repeat (3) step();
    check("rst_digits", digits, 32'h0);
    check("rst_wrap", {31'd0, wrap}, 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < DIV - 1; k++) begin
      check("pre_tick", {31'd0, tick}, 32'd0);
      check("pre_digits", digits, 32'h0);
      step();
    end
    check("first_tick", {31'd0, tick}, 32'd1);
    step();
    check("first_count", digits, 32'h1);
    check("first_tick_low", {31'd0, tick}, 32'd0);
    do_load(32'h0000_0999);
    check("load_999", digits, 32'h0000_0999);
    wait_tick();
    step();
    check("ripple", digits, 32'h0000_1000);
    check("ripple_wrap", {31'd0, wrap}, 32'd0);
    do_load(32'h9999_9999);
    check("load_max", digits, 32'h9999_9999);
    wait_tick();
    step();
    check("up_wrap", digits, 32'h0);
    check("up_wrap_pulse", {31'd0, wrap}, 32'd1);
    step();
    check("up_wrap_end", {31'd0, wrap}, 32'd0);
    check("up_wrap_hold", digits, 32'h0);
    up = 1'b0;
    do_load(32'h0000_1000);
    wait_tick();
    step();
    check("borrow", digits, 32'h0000_0999);
    check("borrow_wrap", {31'd0, wrap}, 32'd0);
    do_load(32'h0);
    wait_tick();
    step();
    check("down_wrap", digits, 32'h9999_9999);
    check("down_wrap_pulse", {31'd0, wrap}, 32'd1);
    step();
    check("down_wrap_end", {31'd0, wrap}, 32'd0);
    up = 1'b1;
    load_val = 32'hFA3C_0007;
    load = 1'b1;
    step();
    check("clamp", digits, 32'h9939_0007);
    saw_tick = 1'b0;
    for (int k = 0; k < DIV + 2; k++) begin
      saw_tick |= tick;
      step();
      check("load_hold", digits, 32'h9939_0007);
      check("load_no_wrap", {31'd0, wrap}, 32'd0);
    end
    check("load_saw_tick", {31'd0, saw_tick}, 32'd1);
    load = 1'b0;
    en = 1'b0;
    held = digits;
    for (int k = 0; k < 3; k++) begin
      wait_tick();
      step();
      check("en_off_hold", digits, held);
    end
    en = 1'b1;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    check("mid_rst_digits", digits, 32'h0);
    check("mid_rst_tick", {31'd0, tick}, 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < DIV - 1; k++) begin
      check("post_rst_no_tick", {31'd0, tick}, 32'd0);
      step();
    end
    check("post_rst_tick", {31'd0, tick}, 32'd1);
    step();
    check("post_rst_count", digits, 32'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bcd_counter8.md
# bcd_counter8

Eight-digit BCD up/down counter that produces the packed 32-bit digit word consumed by the eight-digit seven-segment driver (`SEGDRIVE.inDigit`). An internal prescaler divides the board clock to a slow count rate. The block supports enable, direction and parallel load from switches. Digit 0 (`digits[3:0]`) is the least significant and is shown on the rightmost anode.

## Interface
Parameters:
- `CLK_HZ`, default 100_000_000: input clock frequency.
- `TICK_HZ`, default 10: count rate. `DIV = CLK_HZ/TICK_HZ`, which must be at least 2.

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `en`, in, 1: count enable, sampled only on tick cycles.
- `up`, in, 1: direction; 1 = increment, 0 = decrement.
- `load`, in, 1: level-sensitive parallel load.
- `load_val`, in, 32: eight BCD nibbles to load.
- `digits`, out, 32: packed BCD value, registered; feeds `SEGDRIVE.inDigit`.
- `tick`, out, 1: one-cycle prescaler strobe.
- `wrap`, out, 1: one-cycle pulse, registered, on 99999999↔00000000 rollover.

## Operation
- **Prescaler**
  - `pcnt` counts 0..DIV-1 and wraps to 0.
  - It free-runs regardless of `en` and `load`.
  - `tick = (pcnt == DIV-1)`.
- **Priority per clock edge:** reset > load > count > hold.
- **Reset** (`rst_n`=0 at edge):
  - `digits` = 0 and `pcnt` = 0.
  - `wrap` = 0; `tick` therefore reads 0.
- **Load** (`load`=1):
  - `digits` <= `load_val` nibble-wise.
  - Any nibble above 9 is clamped to 9.
  - `wrap` = 0.
  - Load overrides a coincident tick; that count is lost.
  - The prescaler is unaffected.
- **Count** (`tick`&`en`&!`load`):
  - Up: digit 0 increments, 9→0 carries into the next digit (ripple through all 8).
  - Down: digit 0 decrements, 0→9 borrows from the next digit.
  - Up from 99999999 gives 00000000 with `wrap`=1 for one cycle.
  - Down from 00000000 gives 99999999 with `wrap`=1 for one cycle.
- **Hold:** `digits` unchanged; `wrap` = 0.
- **Invariant:** every `digits` nibble is always ≤ 9.
- **Direction changes:** `up` changing between ticks has no effect until the next tick.

## Timing
- `digits` updates on the edge where `tick` is high; the new value is visible the following cycle.
- First tick after reset release: cycle DIV-1, counting the first cycle with `rst_n`=1 as cycle 0.
- Subsequent ticks occur every DIV cycles.
- `wrap` is asserted in the same cycle the wrapped `digits` value first appears.
- Load latency is 1 cycle.
- Reset asserted mid-count clears everything at the next edge. There is no partial-carry state; the full carry chain resolves combinationally within one cycle.
- `en` deasserted on a tick cycle means no count on that tick.

## Structure
- **Shared package** `seg_pkg`, containing:
  - `bcd_t` (4-bit digit type);
  - `NUM_DIGITS = 8`;
  - `BCD_MAX = 4'd9`.
- **Sub-module** `bcd_digit_cell`, instantiated 8× in a carry chain.
  - Ports: `d_in`, `up`, `cin`, `d_out`, `cout`.
  - Purely combinational increment/decrement of a single digit.
  - `cout` on 9→0 (up) or 0→9 (down).
- **Top level** holds the prescaler, the `digits` register, load clamping and the `wrap` register.
- Digit 0's `cin` = `tick & en`.
- `wrap` = `cout` of digit 7 qualified with `!load`.

## Test plan
Bench uses `CLK_HZ`=10, `TICK_HZ`=1 (DIV=10).
1. **Reset:** hold `rst_n`=0 for 3 cycles, then release with `en`=1, `up`=1.
   - Required: `digits`=0x00000000 and `tick`=0 through cycle 8.
   - Required: `tick` high at cycle 9; `digits`=0x00000001 at cycle 10.
2. **Carry ripple:** load 0x00000999, then `en`=1, `up`=1.
   - Required: next tick gives 0x00001000 and `wrap`=0.
3. **Up wrap:** load 0x99999999, `up`=1.
   - Required: after the tick, `digits`=0x00000000 with `wrap` high for exactly 1 cycle.
4. **Down and borrow wrap:**
   - From 0x00001000 with `up`=0: required 0x00000999.
   - From 0x00000000: required 0x99999999 with `wrap`=1.
5. **Load clamp/priority:** `load_val`=0xFA3C0007 with `load` held across a tick.
   - Required: `digits`=0x99390007.
   - Required: no count applied while `load` is high.
6. **Enable and reset mid-run:**
   - `en`=0 for 3 ticks: required `digits` unchanged.
   - Then `rst_n`=0 at an arbitrary cycle: required `digits`=0 next cycle and `pcnt` restarted (next tick at DIV-1 after release).
